thread_fetch: RTL and testbench

//  Multithreaded instruction fetch stage; producer side of the decode input bundle
//  {instr_pc, instr_thread_id, instr_instr}. Keeps one PC per hardware thread, picks

---
 rtl/thread_fetch_pkg.sv | 31 +++
 rtl/rr_thread_arbiter.sv | 44 ++++
 rtl/thread_fetch.sv | 117 +++++++++++
 tb/tb_thread_fetch.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_fetch_pkg.sv
// Shared types and constants for the multithreaded fetch stage and its decode interface.
package thread_fetch_pkg;

    localparam int XLEN            = 32;
    localparam int INSTR_WIDTH     = 32;
    localparam int NUM_THREADS     = 8;
    localparam int THREAD_ID_WIDTH = 3;
    localparam int FETCH_WIDTH     = XLEN + THREAD_ID_WIDTH + INSTR_WIDTH;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef logic [THREAD_ID_WIDTH-1:0] tid_t;

    // Address tag remembered while the instruction memory read is outstanding.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        tid_t            tid;
    } fetch_tag_t;

    // Field order matches the decode input bundle.
    typedef struct packed {
        logic [XLEN-1:0]        instr_pc;
        tid_t                   instr_thread_id;
        logic [INSTR_WIDTH-1:0] instr_instr;
    } fetch_out_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rr_thread_arbiter.sv
// Round-robin thread picker: combinational grant from the request mask, pointer moves on issue.
module rr_thread_arbiter
    import thread_fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_THREADS-1:0]     req,
    input  logic                       advance,
    output logic [NUM_THREADS-1:0]     grant,
    output logic [THREAD_ID_WIDTH-1:0] grant_tid,
    output logic                       grant_valid
);

    // Highest-priority candidate, i.e. one past the last granted thread.
    logic [THREAD_ID_WIDTH-1:0] next_ptr_q;
    logic [THREAD_ID_WIDTH-1:0] idx;

    always_comb begin
        // NOTE: every output of this block gets a default before the search, so no latch is inferred.
        grant       = '0;
        grant_tid   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        // Index arithmetic wraps naturally because NUM_THREADS == 2**THREAD_ID_WIDTH.
        for (int i = 0; i < NUM_THREADS; i++) begin
            idx = next_ptr_q + THREAD_ID_WIDTH'(i);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_tid   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            next_ptr_q <= '0;
        end else if (advance) begin
            next_ptr_q <= grant_tid + THREAD_ID_WIDTH'(1);
        end
    end

endmodule

// File: rtl/thread_fetch.sv
// Multithreaded fetch: per-thread PCs, round-robin issue, 1-cycle imem, skid-buffered output.
module thread_fetch
    import thread_fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic [NUM_THREADS-1:0]     thread_en_i,
    input  logic                       redirect_valid_i,
    input  logic [THREAD_ID_WIDTH-1:0] redirect_tid_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       imem_rd_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic [INSTR_WIDTH-1:0]     imem_rdata_i,
    output logic                       fetch_valid_o,
    output logic [FETCH_WIDTH-1:0]     fetch_o
);

    logic [XLEN-1:0]        pc_q [NUM_THREADS];
    fetch_tag_t             inflight_q;
    logic                   inflight_valid_q;
    fetch_out_t             skid_q;
    logic                   skid_valid_q;
    fetch_out_t             fetch_q;
    logic                   fetch_valid_q;

    logic [NUM_THREADS-1:0] grant;
    tid_t                   grant_tid;
    logic                   grant_valid;
    logic                   issue;
    logic                   issue_killed;
    logic                   inflight_live;
    logic                   skid_live;
    logic                   fetch_live;
    fetch_out_t             resp;

    rr_thread_arbiter u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (thread_en_i),
        .advance     (issue),
        .grant       (grant),
        .grant_tid   (grant_tid),
        .grant_valid (grant_valid)
    );

    // A redirect squashes every stage holding a packet of the redirected thread.
    always_comb begin
        issue         = rst && grant_valid && !stall_i && !skid_valid_q;
        issue_killed  = redirect_valid_i && (redirect_tid_i == grant_tid);
        inflight_live = inflight_valid_q &&
                        !(redirect_valid_i && (redirect_tid_i == inflight_q.tid));
        skid_live     = skid_valid_q &&
                        !(redirect_valid_i && (redirect_tid_i == skid_q.instr_thread_id));
        fetch_live    = fetch_valid_q &&
                        !(redirect_valid_i && (redirect_tid_i == fetch_q.instr_thread_id));
        resp          = '{instr_pc:        inflight_q.pc,
                          instr_thread_id: inflight_q.tid,
                          instr_instr:     imem_rdata_i};
    end

    assign imem_rd_o     = issue;
    assign imem_addr_o   = issue ? pc_q[grant_tid] : '0;
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_o       = fetch_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the PC file is a register array that must start at RESET_PC, so it is reset explicitly.
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC;
            end
            inflight_valid_q <= 1'b0;
            inflight_q       <= '0;
            skid_valid_q     <= 1'b0;
            skid_q           <= '0;
            fetch_valid_q    <= 1'b0;
            fetch_q          <= '0;
        end else begin
            // Redirect has priority over the post-issue increment of the same thread.
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redirect_valid_i && (redirect_tid_i == tid_t'(t))) begin
                    pc_q[t] <= align_word(redirect_pc_i);
                end else if (issue && grant[t]) begin
                    pc_q[t] <= pc_q[t] + XLEN'(4);
                end
            end

            inflight_valid_q <= issue && !issue_killed;
            if (issue) begin
                inflight_q <= '{pc: pc_q[grant_tid], tid: grant_tid};
            end

            if (stall_i) begin
                fetch_valid_q <= fetch_live;
                if (inflight_live) begin
                    skid_q       <= resp;
                    skid_valid_q <= 1'b1;
                end else begin
                    skid_valid_q <= skid_live;
                end
            end else if (skid_live) begin
                fetch_q       <= skid_q;
                fetch_valid_q <= 1'b1;
                skid_q        <= resp;
                skid_valid_q  <= inflight_live;
            end else begin
                fetch_valid_q <= inflight_live;
                if (inflight_live) begin
                    fetch_q <= resp;
                end
                skid_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_thread_fetch.sv
// Bench for thread_fetch: transaction-queue reference model plus directed scenario checks.
module tb_thread_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_i;
    logic [7:0]   thread_en_i;
    logic         redirect_valid_i;
    logic [2:0]   redirect_tid_i;
    logic [31:0]  redirect_pc_i;
    logic         imem_rd_o;
    logic [31:0]  imem_addr_o;
    logic [31:0]  imem_rdata_i;
    logic         fetch_valid_o;
    logic [66:0]  fetch_o;

    thread_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .thread_en_i      (thread_en_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_tid_i   (redirect_tid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_rd_o        (imem_rd_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_o          (fetch_o)
    );

    always #5 clk = ~clk;

    // Packet as seen by decode; cyc is the cycle in which it was issued to memory.
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  tid;
        logic [31:0] instr;
        int          cyc;
    } pkt_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    pkt_t         pending[$];
    logic [31:0]  m_pc [8];
    int           m_next = 0;
    logic         m_valid = 1'b0;
    pkt_t         m_pres;

    logic         exp_rd;
    logic [2:0]   exp_tid;
    logic [100:0] exp_sig;
    logic [100:0] obs_sig;
    logic         obs_rd;
    logic [31:0]  obs_addr;
    logic         obs_valid;
    logic [66:0]  obs_pkt;
    logic [66:0]  acc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [66:0] pack(input pkt_t p);
        return {p.pc, p.tid, p.instr};
    endfunction

    // Advance the reference model across one clock edge.
    task automatic model_step(input logic r, input logic s, input logic rv,
                              input logic [2:0] rt, input logic [31:0] rp);
        pkt_t keep[$];
        pkt_t p;
        if (!r) begin
            pending.delete();
            m_valid = 1'b0;
            m_next  = 0;
            foreach (m_pc[t]) m_pc[t] = 32'h0;
        end else begin
            if (rv) begin
                foreach (pending[i]) if (pending[i].tid != rt) keep.push_back(pending[i]);
                pending = keep;
                if (m_valid && m_pres.tid == rt) m_valid = 1'b0;
            end
            if (!s) begin
                if (pending.size() > 0 && pending[0].cyc <= cyc - 1) begin
                    m_pres  = pending.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (exp_rd) begin
                if (!(rv && rt == exp_tid)) begin
                    p.pc    = m_pc[exp_tid];
                    p.tid   = exp_tid;
                    p.instr = mem_word(p.pc);
                    p.cyc   = cyc;
                    pending.push_back(p);
                end
                m_pc[exp_tid] = m_pc[exp_tid] + 32'd4;
                m_next = (int'(exp_tid) + 1) % 8;
            end
            if (rv) m_pc[rt] = {rp[31:2], 2'b00};
        end
        cyc++;
    endtask

    // Called just after a rising edge: apply inputs, sample at the falling edge, step the model.
    task automatic drive_cycle(input logic r, input logic s, input logic [7:0] en,
                               input logic rv, input logic [2:0] rt, input logic [31:0] rp);
        logic skid_full;
        rst = r; stall_i = s; thread_en_i = en;
        redirect_valid_i = rv; redirect_tid_i = rt; redirect_pc_i = rp;
        skid_full = 1'b0;
        foreach (pending[i]) if (pending[i].cyc <= cyc - 2) skid_full = 1'b1;
        exp_rd  = r && (en != 8'h00) && !s && !skid_full;
        exp_tid = 3'd0;
        for (int k = 7; k >= 0; k--) if (en[(m_next + k) % 8]) exp_tid = 3'((m_next + k) % 8);
        exp_sig = {exp_rd, exp_rd ? m_pc[exp_tid] : 32'h0, m_valid, m_valid ? pack(m_pres) : 67'h0};
        @(negedge clk);
        obs_rd    = imem_rd_o;
        obs_addr  = imem_addr_o;
        obs_valid = fetch_valid_o;
        obs_pkt   = fetch_o;
        obs_sig   = {obs_rd, obs_rd ? obs_addr : 32'h0, obs_valid, obs_valid ? obs_pkt : 67'h0};
        if (obs_valid === 1'b1 && !s) acc_q.push_back(obs_pkt);
        @(posedge clk);
        model_step(r, s, rv, rt, rp);
        #1;
        imem_rdata_i = (obs_rd === 1'b1) ? mem_word(obs_addr) : $urandom;
    endtask

    task automatic apply_reset();
        for (int c = 0; c < 2; c++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 32'h0);
        acc_q.delete();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 3'($urandom), $urandom);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
            checks++;
            if ({obs_rd, obs_addr, obs_valid, obs_pkt} !== 101'h0) begin
                errors++;
                $display("FAIL reset_outputs rd=%b addr=%h valid=%b pkt=%h want all zero",
                         obs_rd, obs_addr, obs_valid, obs_pkt);
            end
        end
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 32'h0);
        checks++;
        if ({obs_rd, obs_valid, obs_pkt} !== 69'h0) begin
            errors++;
            $display("FAIL reset_release rd=%b valid=%b pkt=%h want all zero", obs_rd, obs_valid, obs_pkt);
        end
    endtask

    task automatic test_single_thread();
        int first_rd = -1;
        int first_v  = -1;
        logic [66:0] want;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1'b1, 1'b0, 8'h01, 1'b0, 3'd0, 32'h0);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
            if (obs_rd === 1'b1 && first_rd < 0) first_rd = c;
            if (obs_valid === 1'b1 && first_v < 0) first_v = c;
        end
        checks++;
        if (first_rd != 0 || first_v != 2) begin
            errors++;
            $display("FAIL single_latency first_rd=%0d first_valid=%0d want 0 and 2", first_rd, first_v);
        end
        checks++;
        if (acc_q.size() < 3) begin
            errors++;
            $display("FAIL single_count got=%0d want>=3", acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                want = {32'(4 * i), 3'd0, mem_word(32'(4 * i))};
                checks++;
                if (acc_q[i] !== want) begin
                    errors++;
                    $display("FAIL single_pkt%0d got=%h want=%h", i, acc_q[i], want);
                end
            end
        end
    endtask

    task automatic test_all_threads();
        logic [66:0] want;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 32'h0);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
        end
        checks++;
        if (acc_q.size() < 10) begin
            errors++;
            $display("FAIL rr_count got=%0d want>=10", acc_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                want = {32'(4 * (k / 8)), 3'(k % 8), mem_word(32'(4 * (k / 8)))};
                checks++;
                if (acc_q[k] !== want) begin
                    errors++;
                    $display("FAIL rr_pkt%0d got=%h want=%h", k, acc_q[k], want);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [66:0] held_pkt;
        logic        held_v;
        logic        s;
        apply_reset();
        for (int c = 0; c < 13; c++) begin
            s = (c >= 4 && c <= 6);
            drive_cycle(1'b1, s, 8'h01, 1'b0, 3'd0, 32'h0);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL stall_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
            if (c == 4) begin
                held_pkt = obs_pkt;
                held_v   = obs_valid;
                checks++;
                if (held_v !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_entry_valid got=%b want=1", held_v);
                end
            end
            if (s) begin
                checks++;
                if (obs_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_rd cyc=%0d got=%b want=0", c, obs_rd);
                end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (obs_pkt !== held_pkt || obs_valid !== held_v) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got=%b/%h want=%b/%h", c, obs_valid, obs_pkt, held_v, held_pkt);
                end
            end
        end
        checks++;
        if (acc_q.size() < 5) begin
            errors++;
            $display("FAIL stall_count got=%0d want>=5", acc_q.size());
        end else begin
            foreach (acc_q[i]) begin
                checks++;
                if (acc_q[i][66:35] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL stall_seq%0d got=%h want=%h", i, acc_q[i][66:35], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect();
        int          squashed = 0;
        logic [31:0] first2 = 32'hDEAD_BEEF;
        logic [31:0] first3 = 32'hDEAD_BEEF;
        logic        seen2 = 1'b0;
        logic        seen3 = 1'b0;
        apply_reset();
        for (int c = 0; c < 22; c++) begin
            drive_cycle(1'b1, 1'b0, 8'hFF, c == 3, 3'd2, 32'h0000_0103);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL redirect_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
        end
        foreach (acc_q[i]) begin
            if (acc_q[i][34:32] == 3'd2) begin
                if (acc_q[i][66:35] == 32'h0) squashed++;
                if (!seen2) begin first2 = acc_q[i][66:35]; seen2 = 1'b1; end
            end
            if (acc_q[i][34:32] == 3'd3 && !seen3) begin first3 = acc_q[i][66:35]; seen3 = 1'b1; end
        end
        checks++;
        if (squashed != 0) begin
            errors++;
            $display("FAIL redirect_squash got=%0d stale packets want 0", squashed);
        end
        checks++;
        if (first2 !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redirect_new_pc got=%h want=00000100", first2);
        end
        checks++;
        if (first3 !== 32'h0) begin
            errors++;
            $display("FAIL redirect_other got=%h want=00000000", first3);
        end
    endtask

    task automatic test_no_threads();
        apply_reset();
        for (int c = 0; c < 5; c++) drive_cycle(1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 32'h0);
        for (int d = 0; d < 4; d++) begin
            drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 32'h0);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL idle_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
            checks++;
            if (obs_rd !== 1'b0 || (d >= 2 && obs_valid !== 1'b0)) begin
                errors++;
                $display("FAIL idle_drain d=%0d rd=%b valid=%b want rd=0 valid=0 from d=2", d, obs_rd, obs_valid);
            end
        end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 32'hFFFF_FFFF);
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1'b1, 1'b0, 8'h01, 1'b0, 3'd0, 32'h0);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL wrap_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
        end
        checks++;
        if (acc_q.size() < 2) begin
            errors++;
            $display("FAIL wrap_count got=%0d want>=2", acc_q.size());
        end else begin
            checks++;
            if (acc_q[0][66:32] !== {32'hFFFF_FFFC, 3'd0} || acc_q[1][66:32] !== {32'h0, 3'd0}) begin
                errors++;
                $display("FAIL wrap_pcs got=%h,%h want=fffffffc,00000000",
                         acc_q[0][66:35], acc_q[1][66:35]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] en;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            drive_cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, en,
                        $urandom_range(0, 5) == 0, 3'($urandom), $urandom);
            checks++;
            if (obs_sig !== exp_sig) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", cyc - 1, obs_sig, exp_sig);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; stall_i = 1'b0; thread_en_i = 8'h00;
        redirect_valid_i = 1'b0; redirect_tid_i = 3'd0; redirect_pc_i = 32'h0;
        imem_rdata_i = 32'h0;
        foreach (m_pc[t]) m_pc[t] = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_thread();
        test_all_threads();
        test_stall();
        test_redirect();
        test_no_threads();
        test_pc_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
